// File: rtl/videogen_pkg.sv
// Shared codes and constants for the multi-pattern video timing generator.
package videogen_pkg;

   typedef enum logic [2:0] {
      PAT_BLACK   = 3'd0,
      PAT_BARS    = 3'd1,
      PAT_CHECKER = 3'd2,
      PAT_RAMP    = 3'd3,
      PAT_NOISE   = 3'd4,
      PAT_LATENCY = 3'd5
   } pattern_e;

   typedef enum logic [1:0] {
      LT_OFF      = 2'd0,
      LT_TOPLEFT  = 2'd1,
      LT_CENTRE   = 2'd2,
      LT_BOTRIGHT = 2'd3
   } lt_pos_e;

   // Fibonacci taps at bits 15, 14, 12 and 3
   localparam logic [15:0] LFSR_TAPS   = 16'hD008;
   // Grey level of a lit noise pixel, expressed for an 8-bit channel
   localparam logic [7:0]  NOISE_LEVEL = 8'hCF;
   // Latency box is 1/BOX_DIV of the active area in each direction
   localparam int          BOX_DIV     = 4;

   // Rescale an 8-bit level to a w-bit channel (MSB aligned)
   function automatic logic [31:0] scale8(input logic [7:0] v, input int w);
      if (w >= 8) return 32'(v) << (w - 8);
      return 32'(v) >> (8 - w);
   endfunction

endpackage

// File: rtl/videogen_multi_lfsr16_step.sv
// One step of the 16-bit Fibonacci noise LFSR; feedback enters at the LSB.
module lfsr16_step
   import videogen_pkg::*;
(
   input  logic [15:0] state_i,
   output logic [15:0] state_o
);

   assign state_o = {state_i[14:0], ^(state_i & LFSR_TAPS)};

endmodule

// File: rtl/videogen_multi.sv
// Parametrised raster timing generator with six test patterns. All outputs
// except PCLK_out are registered one clock after the counter position they
// are decoded from; pattern controls are latched at pixel (0,0).
module videogen_multi
   import videogen_pkg::*;
#(
   parameter int          H_SYNCLEN    = 62,
   parameter int          H_BACKPORCH  = 60,
   parameter int          H_ACTIVE     = 720,
   parameter int          H_FRONTPORCH = 16,
   parameter int          V_SYNCLEN    = 6,
   parameter int          V_BACKPORCH  = 30,
   parameter int          V_ACTIVE     = 480,
   parameter int          V_FRONTPORCH = 9,
   parameter int          CNT_W        = 11,
   parameter int          COLOR_W      = 8,
   parameter logic        HS_POL       = 1'b0,
   parameter logic        VS_POL       = 1'b0,
   parameter logic [15:0] LFSR_SEED    = 16'h0001
) (
   input  logic               clk27,
   input  logic               reset_n,
   input  logic [2:0]         pattern_sel,
   input  logic [1:0]         lt_mode,
   input  logic               scroll_en,
   output logic [COLOR_W-1:0] R_out,
   output logic [COLOR_W-1:0] G_out,
   output logic [COLOR_W-1:0] B_out,
   output logic               HSYNC_out,
   output logic               VSYNC_out,
   output logic               PCLK_out,
   output logic               ENABLE_out,
   output logic               frame_start,
   output logic [15:0]        frame_cnt
);

   localparam int H_TOTAL = H_SYNCLEN + H_BACKPORCH + H_ACTIVE + H_FRONTPORCH;
   localparam int V_TOTAL = V_SYNCLEN + V_BACKPORCH + V_ACTIVE + V_FRONTPORCH;
   localparam int XW      = CNT_W + 3;

   localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
   localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);
   localparam logic [CNT_W-1:0] H_SL   = CNT_W'(H_SYNCLEN);
   localparam logic [CNT_W-1:0] V_SL   = CNT_W'(V_SYNCLEN);
   localparam logic [CNT_W-1:0] X_S    = CNT_W'(H_SYNCLEN + H_BACKPORCH);
   localparam logic [CNT_W-1:0] Y_S    = CNT_W'(V_SYNCLEN + V_BACKPORCH);
   localparam logic [CNT_W-1:0] X_E    = CNT_W'(H_SYNCLEN + H_BACKPORCH + H_ACTIVE);
   localparam logic [CNT_W-1:0] Y_E    = CNT_W'(V_SYNCLEN + V_BACKPORCH + V_ACTIVE);
   localparam logic [CNT_W-1:0] X_LAST = CNT_W'(H_SYNCLEN + H_BACKPORCH + H_ACTIVE - 1);

   localparam logic [CNT_W-1:0] BOX_W  = CNT_W'(H_ACTIVE / BOX_DIV);
   localparam logic [CNT_W-1:0] BOX_H  = CNT_W'(V_ACTIVE / BOX_DIV);
   localparam logic [CNT_W-1:0] BX_C   = CNT_W'((H_ACTIVE - H_ACTIVE / BOX_DIV) / 2);
   localparam logic [CNT_W-1:0] BY_C   = CNT_W'((V_ACTIVE - V_ACTIVE / BOX_DIV) / 2);
   localparam logic [CNT_W-1:0] BX_R   = CNT_W'(H_ACTIVE - H_ACTIVE / BOX_DIV);
   localparam logic [CNT_W-1:0] BY_R   = CNT_W'(V_ACTIVE - V_ACTIVE / BOX_DIV);

   localparam logic [COLOR_W-1:0] FULL      = '1;
   localparam logic [COLOR_W-1:0] NOISE_LVL = COLOR_W'(scale8(NOISE_LEVEL, COLOR_W));

   logic [CNT_W-1:0]   h_q, h_d, v_q, v_d;
   logic [2:0]         pat_q;
   logic [1:0]         lt_q;
   logic               scroll_q;
   logic [15:0]        frame_cnt_q;
   logic [15:0]        lfsr_q, lfsr_d, seed_q, seed_d, seed_next_q, seed_next_d, lfsr_step;

   logic               frame_pos, act, in_box;
   logic [CNT_W-1:0]   x, y, bx0, by0;
   logic [XW-1:0]      x8;
   logic [2:0]         bar_idx, bar_col;
   logic               hs_d, vs_d;
   logic [COLOR_W-1:0] r_d, g_d, b_d;

   logic               hs_q, vs_q, en_q, fs_q;
   logic [COLOR_W-1:0] r_q, g_q, b_q;

   lfsr16_step u_step (
      .state_i (lfsr_q),
      .state_o (lfsr_step)
   );

   // Raster counter next state: h wraps each line, v advances on line wrap
   always_comb begin
      h_d = h_q + 1'b1;
      v_d = v_q;
      if (h_q == H_LAST) begin
         h_d = '0;
         v_d = (v_q == V_LAST) ? '0 : v_q + 1'b1;
      end
   end

   assign frame_pos = (h_q == '0) && (v_q == '0);
   assign act       = (h_q >= X_S) && (h_q < X_E) && (v_q >= Y_S) && (v_q < Y_E);
   assign x         = h_q - X_S;
   assign y         = v_q - Y_S;
   assign hs_d      = (h_q < H_SL) ? HS_POL : ~HS_POL;
   assign vs_d      = (v_q < V_SL) ? VS_POL : ~VS_POL;

   // Pattern decode for the current counter position
   always_comb begin
      // bar index = floor(x*8/H_ACTIVE) via thresholds k*H_ACTIVE on x*8
      x8      = {x, 3'b000};
      bar_idx = 3'd0;
      for (int k = 1; k < 8; k++)
         if (x8 >= XW'(k * H_ACTIVE)) bar_idx = 3'(k);
      bar_col = 3'd7 - bar_idx;

      case (lt_q)
         LT_CENTRE:   begin bx0 = BX_C; by0 = BY_C; end
         LT_BOTRIGHT: begin bx0 = BX_R; by0 = BY_R; end
         default:     begin bx0 = '0;   by0 = '0;   end
      endcase
      in_box = (lt_q != LT_OFF) && (x >= bx0) && (x < bx0 + BOX_W)
               && (y >= by0) && (y < by0 + BOX_H);

      r_d = '0;
      g_d = '0;
      b_d = '0;
      if (act) begin
         case (pat_q)
            PAT_BARS: begin
               r_d = {COLOR_W{bar_col[2]}};
               g_d = {COLOR_W{bar_col[1]}};
               b_d = {COLOR_W{bar_col[0]}};
            end
            PAT_CHECKER: if (h_q[0] ^ v_q[0]) begin r_d = FULL; g_d = FULL; b_d = FULL; end
            PAT_RAMP: begin
               r_d = COLOR_W'(x);
               g_d = COLOR_W'(x);
               b_d = COLOR_W'(x);
            end
            PAT_NOISE: if (&lfsr_q[15:13]) begin r_d = NOISE_LVL; g_d = NOISE_LVL; b_d = NOISE_LVL; end
            PAT_LATENCY: if (in_box) begin r_d = FULL; g_d = FULL; b_d = FULL; end
            default: ;
         endcase
      end
   end

   // Noise generator: reload at frame start, step on active pixels, remember
   // the state that begins active line 1 so the next frame can start there
   always_comb begin
      seed_d      = seed_q;
      lfsr_d      = lfsr_q;
      seed_next_d = seed_next_q;
      if (frame_pos) begin
         seed_d = scroll_q ? seed_next_q : seed_q;
         lfsr_d = seed_d;
      end else if (act) begin
         lfsr_d = lfsr_step;
         if ((h_q == X_LAST) && (v_q == Y_S)) seed_next_d = lfsr_step;
      end
   end

   // Raster position counters
   always_ff @(posedge clk27 or negedge reset_n) begin
      if (!reset_n) begin
         h_q <= '0;
         v_q <= '0;
      end else begin
         h_q <= h_d;
         v_q <= v_d;
      end
   end

   // Frame-boundary latch of pattern controls and frame counter
   always_ff @(posedge clk27 or negedge reset_n) begin
      if (!reset_n) begin
         pat_q       <= PAT_BLACK;
         lt_q        <= LT_OFF;
         scroll_q    <= 1'b0;
         frame_cnt_q <= '0;
      end else if (frame_pos) begin
         pat_q       <= pattern_sel;
         lt_q        <= lt_mode;
         scroll_q    <= scroll_en;
         frame_cnt_q <= frame_cnt_q + 16'd1;
      end
   end

   // Noise LFSR state and seed registers
   always_ff @(posedge clk27 or negedge reset_n) begin
      if (!reset_n) begin
         lfsr_q      <= LFSR_SEED;
         seed_q      <= LFSR_SEED;
         seed_next_q <= LFSR_SEED;
      end else begin
         lfsr_q      <= lfsr_d;
         seed_q      <= seed_d;
         seed_next_q <= seed_next_d;
      end
   end

   // Output register stage, one clock behind the counters
   always_ff @(posedge clk27 or negedge reset_n) begin
      if (!reset_n) begin
         hs_q <= HS_POL;
         vs_q <= VS_POL;
         en_q <= 1'b0;
         fs_q <= 1'b0;
         r_q  <= '0;
         g_q  <= '0;
         b_q  <= '0;
      end else begin
         hs_q <= hs_d;
         vs_q <= vs_d;
         en_q <= act;
         fs_q <= frame_pos;
         r_q  <= r_d;
         g_q  <= g_d;
         b_q  <= b_d;
      end
   end

   assign R_out       = r_q;
   assign G_out       = g_q;
   assign B_out       = b_q;
   assign HSYNC_out   = hs_q;
   assign VSYNC_out   = vs_q;
   assign ENABLE_out  = en_q;
   assign frame_start = fs_q;
   assign frame_cnt   = frame_cnt_q;
   assign PCLK_out    = clk27;

endmodule
